// File: rtl/cvp14_pkg.sv
// Shared constants, opcodes and FSM state type for the CVP14 vector coprocessor.
package cvp14_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned VLEN  = 16;
  localparam int unsigned NVREG = 8;
  localparam int unsigned NSREG = 8;
  localparam int unsigned RW    = 3;
  localparam int unsigned EW    = 4;
  localparam int unsigned CW    = 5;

  localparam logic [3:0] OP_VADD = 4'h0;
  localparam logic [3:0] OP_VDOT = 4'h1;
  localparam logic [3:0] OP_SMUL = 4'h2;
  localparam logic [3:0] OP_SADD = 4'h3;
  localparam logic [3:0] OP_VLD  = 4'h4;
  localparam logic [3:0] OP_VST  = 4'h5;
  localparam logic [3:0] OP_LDL  = 4'h6;
  localparam logic [3:0] OP_LDH  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // Two's-complement overflow of s = a + b.
  function automatic logic add_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] s);
    return (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
  endfunction

endpackage

// File: rtl/cvp14_vrf.sv
// Vector register file: NVREG x VLEN x DW, two element read ports and one element write port.
module cvp14_vrf
  import cvp14_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] ra,
  input  logic [EW-1:0] ea,
  output logic [DW-1:0] rda_c,
  input  logic [RW-1:0] rb,
  input  logic [EW-1:0] eb,
  output logic [DW-1:0] rdb_c,
  input  logic          we,
  input  logic [RW-1:0] wsel,
  input  logic [EW-1:0] wel,
  input  logic [DW-1:0] wd
);

  localparam int unsigned NENT = NVREG * VLEN;

  logic [DW-1:0] mem [NENT];

  assign rda_c = mem[{ra, ea}];
  assign rdb_c = mem[{rb, eb}];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NENT; i++) mem[i] <= '0;
    end else if (we) begin
      mem[{wsel, wel}] <= wd;
    end
  end

endmodule

// File: rtl/cvp14_core.sv
// CVP14 vector coprocessor: fetch/decode/execute FSM, scalar file and element-serial ALU.
// Define CVP14_VDOT_EN to implement VDOT; otherwise opcode 0x1 is a NOP.
module cvp14_core
  import cvp14_pkg::*;
(
  input  logic          Clk1,
  input  logic          Reset,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] Addr,
  output logic          RD,
  output logic          WR,
  output logic [DW-1:0] DataOut,
  output logic          V
);

  state_t        state;
  logic [DW-1:0] pc;
  logic [DW-1:0] ir;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sreg [NSREG];

  logic [3:0]    op;
  logic [RW-1:0] fd, fa, fb;
  logic [7:0]    imm;
  logic [3:0]    in_op;
  logic [RW-1:0] in_d, in_a;

  assign op    = ir[15:12];
  assign fd    = ir[11:9];
  assign fa    = ir[8:6];
  assign fb    = ir[5:3];
  assign imm   = ir[7:0];
  assign in_op = DataIn[15:12];
  assign in_d  = DataIn[11:9];
  assign in_a  = DataIn[8:6];

  logic [RW-1:0] ra, rb, wsel;
  logic [EW-1:0] ea, eb, wel;
  logic [DW-1:0] rda, rdb, wd;
  logic          vwe;

  cvp14_vrf u_vrf (
    .clk   (Clk1),
    .reset (Reset),
    .ra    (ra),
    .ea    (ea),
    .rda_c (rda),
    .rb    (rb),
    .eb    (eb),
    .rdb_c (rdb),
    .we    (vwe),
    .wsel  (wsel),
    .wel   (wel),
    .wd    (wd)
  );

  logic [DW-1:0]        sa, sb, vsum, ssum;
  logic                 vsum_ovf, ssum_ovf, smul_ovf;
  logic signed [PW-1:0] prod;

  assign sa       = sreg[fa];
  assign sb       = sreg[fb];
  assign vsum     = rda + rdb;
  assign ssum     = sa + sb;
  assign vsum_ovf = add_ovf(rda, rdb, vsum);
  assign ssum_ovf = add_ovf(sa, sb, ssum);
  assign prod     = PW'($signed(rda)) * PW'($signed(sb));
  // Product fits in 16 signed bits only if bits [31:15] are all equal.
  assign smul_ovf = !((&prod[PW-1:DW-1]) || !(|prod[PW-1:DW-1]));

`ifdef CVP14_VDOT_EN
  logic [DW-1:0] acc, dprod;
  assign dprod = DW'(rda * rdb);
`endif

  // Read select: DECODE prefetches element 0 of a VST source; VST runs one element ahead.
  always_comb begin
    ra = fa;
    ea = cnt[EW-1:0];
    rb = fb;
    eb = cnt[EW-1:0];
    if (state == S_DECODE) begin
      ra = in_d;
      ea = '0;
    end else if (op == OP_VST) begin
      ra = fd;
      ea = cnt[EW-1:0] + EW'(1);
    end
  end

  // Element write port; VLD writes the word read on the previous cycle.
  always_comb begin
    vwe  = 1'b0;
    wsel = fd;
    wel  = cnt[EW-1:0];
    wd   = vsum;
    if (state == S_EXEC) begin
      case (op)
        OP_VADD: vwe = 1'b1;
        OP_SMUL: begin
          vwe = 1'b1;
          wd  = prod[DW-1:0];
        end
        OP_VLD: begin
          vwe = (cnt != '0);
          wel = EW'(cnt - CW'(1));
          wd  = DataIn;
        end
        default: ;
      endcase
    end
  end

  logic done;

  always_comb begin
    case (op)
      OP_VADD, OP_SMUL, OP_VST: done = (cnt == CW'(VLEN - 1));
`ifdef CVP14_VDOT_EN
      OP_VDOT: done = (cnt == CW'(VLEN - 1));
`endif
      OP_VLD:  done = (cnt == CW'(VLEN));
      default: done = 1'b1;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      cnt     <= '0;
      Addr    <= '0;
      RD      <= 1'b0;
      WR      <= 1'b0;
      DataOut <= '0;
      V       <= 1'b0;
`ifdef CVP14_VDOT_EN
      acc     <= '0;
`endif
      for (int unsigned i = 0; i < NSREG; i++) sreg[i] <= '0;
    end else begin
      case (state)
        // The first fetch after reset spends one cycle raising RD.
        S_FETCH: begin
          if (RD) begin
            RD    <= 1'b0;
            state <= S_DECODE;
          end else begin
            RD   <= 1'b1;
            Addr <= pc;
          end
        end
        S_DECODE: begin
          ir    <= DataIn;
          pc    <= pc + DW'(1);
          cnt   <= '0;
          state <= S_EXEC;
`ifdef CVP14_VDOT_EN
          acc   <= '0;
`endif
          case (in_op)
            OP_HALT: state <= S_HALT;
            OP_VLD: begin
              RD   <= 1'b1;
              Addr <= sreg[in_a];
            end
            OP_VST: begin
              WR      <= 1'b1;
              Addr    <= sreg[in_a];
              DataOut <= rda;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          case (op)
            OP_VADD: V <= V | vsum_ovf;
            OP_SMUL: V <= V | smul_ovf;
`ifdef CVP14_VDOT_EN
            OP_VDOT: begin
              acc <= acc + dprod;
              if (done) sreg[fd] <= acc + dprod;
            end
`endif
            OP_SADD: begin
              sreg[fd] <= ssum;
              V        <= V | ssum_ovf;
            end
            OP_VLD: begin
              if (cnt < CW'(VLEN - 1)) begin
                RD   <= 1'b1;
                Addr <= Addr + DW'(1);
              end else begin
                RD <= 1'b0;
              end
            end
            OP_VST: begin
              if (cnt < CW'(VLEN - 1)) begin
                WR      <= 1'b1;
                Addr    <= Addr + DW'(1);
                DataOut <= rda;
              end else begin
                WR <= 1'b0;
              end
            end
            OP_LDL:  sreg[fd] <= {sreg[fd][15:8], imm};
            OP_LDH:  sreg[fd] <= {imm, sreg[fd][7:0]};
            default: ;
          endcase
          // Completion launches the next instruction fetch directly.
          if (done) begin
            state <= S_FETCH;
            RD    <= 1'b1;
            WR    <= 1'b0;
            Addr  <= pc;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          RD <= 1'b0;
          WR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cvp14_core.sv
// Self-checking bench for cvp14_core: instruction-level reference model plus directed program checks.
module tb_cvp14_core;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] DataIn, Addr, DataOut;
  logic        RD, WR, V;

  logic [15:0] mem [65536];
  logic [15:0] rdata = '0;

  int errors = 0;
  int checks = 0;

  cvp14_core dut (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .DataIn  (DataIn),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .V       (V)
  );

  always #5 Clk1 = ~Clk1;

  assign DataIn = rdata;

  // Memory: writes commit at the edge, reads return on the following cycle.
  always @(posedge Clk1) begin
    if (WR) mem[Addr] <= DataOut;
    if (RD) rdata <= mem[Addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Instruction-level reference model.
  logic [15:0] mm [65536];
  logic [15:0] ms [8];
  logic [15:0] mv [8][16];
  logic        mvf;
  int          mcycles, mreads;
  logic [15:0] mpc_halt;
  logic [15:0] exp_wa [$];
  logic [15:0] exp_wd [$];

  function automatic int sx(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic fits(input int s);
    return (s >= -32768) && (s <= 32767);
  endfunction

  task automatic run_model();
    logic [15:0] pc, ins, ad;
    logic [3:0]  op;
    int          d, a, b, s;
    longint      acc;
    bit          halted;
    pc = '0; mcycles = 1; mreads = 0; mvf = 1'b0; halted = 1'b0;
    for (int n = 0; n < 1000 && !halted; n++) begin
      ins = mm[pc];
      pc  = pc + 16'd1;
      mreads++;
      op = ins[15:12]; d = int'(ins[11:9]); a = int'(ins[8:6]); b = int'(ins[5:3]);
      case (op)
        4'h0: begin
          for (int i = 0; i < 16; i++) begin
            s = sx(mv[a][i]) + sx(mv[b][i]);
            if (!fits(s)) mvf = 1'b1;
            mv[d][i] = 16'(s);
          end
          mcycles += 18;
        end
`ifdef CVP14_VDOT_EN
        4'h1: begin
          acc = 0;
          for (int i = 0; i < 16; i++) acc += longint'(mv[a][i]) * longint'(mv[b][i]);
          ms[d] = 16'(acc);
          mcycles += 18;
        end
`endif
        4'h2: begin
          for (int i = 0; i < 16; i++) begin
            s = sx(mv[a][i]) * sx(ms[b]);
            if (!fits(s)) mvf = 1'b1;
            mv[d][i] = 16'(s);
          end
          mcycles += 18;
        end
        4'h3: begin
          s = sx(ms[a]) + sx(ms[b]);
          if (!fits(s)) mvf = 1'b1;
          ms[d] = 16'(s);
          mcycles += 3;
        end
        4'h4: begin
          for (int i = 0; i < 16; i++) begin
            ad = ms[a] + 16'(i);
            mv[d][i] = mm[ad];
          end
          mreads += 16;
          mcycles += 19;
        end
        4'h5: begin
          for (int i = 0; i < 16; i++) begin
            ad = ms[a] + 16'(i);
            mm[ad] = mv[d][i];
            exp_wa.push_back(ad);
            exp_wd.push_back(mv[d][i]);
          end
          mcycles += 18;
        end
        4'h6: begin ms[d][7:0] = ins[7:0]; mcycles += 3; end
        4'h7: begin ms[d][15:8] = ins[7:0]; mcycles += 3; end
        4'hF: begin mcycles += 2; mpc_halt = pc; halted = 1'b1; end
        default: mcycles += 3;
      endcase
    end
  endtask

  // Per-cycle compare against the model's write stream.
  bit mon_en = 1'b0;
  bit chk_wr = 1'b0;
  int rd_count = 0, wr_count = 0, wr40 = 0;

  always @(negedge Clk1) begin
    if (mon_en) begin
      check("rd_wr_exclusive", 32'(RD & WR), 32'd0);
      if (RD) rd_count++;
      if (WR) begin
        wr_count++;
        if (Addr >= 16'h0040 && Addr <= 16'h004F) wr40++;
        if (chk_wr) begin
          if (exp_wa.size() == 0) check("unexpected_write", {Addr, DataOut}, 32'hDEADDEAD);
          else check("write_addr_data", {Addr, DataOut}, {exp_wa.pop_front(), exp_wd.pop_front()});
        end
      end
    end
  end

  logic [15:0] prog [16] = '{
    16'h6010, 16'h4000, 16'h6240, 16'h0200, 16'h5240, 16'h1E00, 16'h64FF, 16'h747F,
    16'h3690, 16'h2408, 16'h6AF8, 16'h7AFF, 16'h5540, 16'h0008, 16'h5000, 16'hF000
  };
  logic [15:0] prog2 [5] = '{16'h64FF, 16'h747F, 16'h3690, 16'h5080, 16'hF000};

  logic [15:0] exp_s7;

  initial begin
`ifdef CVP14_VDOT_EN
    exp_s7 = 16'h04D8;
`else
    exp_s7 = 16'h0000;
`endif
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; mm[i] = '0; end
    for (int i = 0; i < 16; i++) begin
      mem[i] = prog[i]; mm[i] = prog[i];
      mem[16 + i] = 16'(i); mm[16 + i] = 16'(i);
    end
    for (int r = 0; r < 8; r++) begin
      ms[r] = '0;
      for (int i = 0; i < 16; i++) mv[r][i] = '0;
    end
    run_model();

    // Hand-computed pins on the model itself.
    check("model_s3", 32'(ms[3]), 32'h0000FFFE);
    check("model_s7", 32'(ms[7]), 32'(exp_s7));
    check("model_v", 32'(mvf), 32'd1);

    repeat (3) @(posedge Clk1);
    @(negedge Clk1);
    check("reset_rd", 32'(RD), 32'd0);
    check("reset_wr", 32'(WR), 32'd0);
    check("reset_v", 32'(V), 32'd0);
    check("reset_addr", 32'(Addr), 32'd0);
    check("reset_dataout", 32'(DataOut), 32'd0);
    check("reset_pc", 32'(dut.pc), 32'd0);
    Reset = 1'b0;
    mon_en = 1'b1;
    chk_wr = 1'b1;

    repeat (mcycles + 10) @(negedge Clk1);
    for (int c = 0; c < 100; c++) begin
      check("halt_pc", 32'(dut.pc), 32'(mpc_halt));
      check("halt_strobes", {30'd0, RD, WR}, 32'd0);
      @(negedge Clk1);
    end

    check("writes_outstanding", 32'(exp_wa.size()), 32'd0);
    check("read_pulses", 32'(rd_count), 32'(mreads));
    check("v_flag", 32'(V), 32'(mvf));
    for (int r = 0; r < 8; r++) check("sreg", 32'(dut.sreg[r]), 32'(ms[r]));
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 16; i++) check("vreg", 32'(dut.u_vrf.mem[r * 16 + i]), 32'(mv[r][i]));

    // Literal expectations for the directed program.
    for (int i = 0; i < 16; i++) check("mem_0x40", 32'(mem[16'h40 + 16'(i)]), 32'(2 * i));
    for (int i = 0; i < 16; i++) check("mem_0x10", 32'(mem[16'h10 + 16'(i)]), 32'(3 * i));
    check("wr_pulses_0x40", 32'(wr40), 32'd16);
    check("s7", 32'(dut.sreg[7]), 32'(exp_s7));
    check("s3", 32'(dut.sreg[3]), 32'h0000FFFE);
    check("v_set", 32'(V), 32'd1);
    check("wrap_hi", 32'(mem[16'hFFFF]), 32'h000001C0);
    check("wrap_lo", 32'(mem[16'h0000]), 32'h00000200);

    // Reset in the middle of a VST.
    mon_en = 1'b0;
    chk_wr = 1'b0;
    Reset = 1'b1;
    @(posedge Clk1);
    for (int i = 0; i < 5; i++) mem[i] = prog2[i];
    @(negedge Clk1);
    wr_count = 0;
    Reset = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 300 && wr_count < 5; c++) @(negedge Clk1);
    check("mid_vst_reached", 32'(wr_count >= 5), 32'd1);
    check("mid_vst_v", 32'(V), 32'd1);
    Reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk1);
      check("abort_wr", 32'(WR), 32'd0);
      check("abort_rd", 32'(RD), 32'd0);
      check("abort_pc", 32'(dut.pc), 32'd0);
      check("abort_v", 32'(V), 32'd0);
    end
    check("abort_sreg", 32'(dut.sreg[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
